result_hex_display: RTL
=======================

// Module: result_hex_display
// PURPOSE
//   Downstream stage of the matrix-vector multiplier. Captures the 8-bit product
//   on a valid strobe and shows it on the single 7-segment display as two hex
//   nibbles: high nibble first with the decimal point lit, then the low nibble
//   with the decimal point off. The block alternates between the two for a fixed
//   number of passes, then blanks. Its output drives uo_out directly.
// PARAMETERS
//   DWELL_CYCLES  24'd10_000_000  clock cycles each nibble is shown (must be >= 1)
//   REPEATS       4'd3            number of HI/LO pairs before blanking; 0 = repeat forever
// PORTS
//   clk           in   1  system clock
//   rst_n         in   1  asynchronous active-low reset
//   ena           in   1  design enable; low freezes all state
//   result_in     in   8  multiplier product to display
//   result_valid  in   1  single-cycle strobe: capture result_in
//   seg_out       out  8  [6:0] = segments a..g (bit0 = a), active high; [7] = dp
//   busy          out  1  high while a value is being displayed
// BEHAVIOUR
//   Reset
//   - One clock; reset is asynchronous and active-low (rst_n).
//   - On reset: state = IDLE, seg_out = 8'h00, busy = 0, hold register = 0,
//     dwell counter = 0, pass counter = 0. Reset mid-display aborts at once.
//   Registers and enable
//   - All outputs are registered.
//   - When ena = 0, every register holds its value. result_valid is ignored.
//   States
//   - IDLE: seg_out = 0, busy = 0.
//   - SHOW_HI: seg_out = {1'b1, hex(hold[7:4])}, busy = 1.
//   - SHOW_LO: seg_out = {1'b0, hex(hold[3:0])}, busy = 1.
//   Capture
//   - Trigger: result_valid = 1 and ena = 1, in any state.
//   - Action: hold <= result_in, state <= SHOW_HI, dwell <= 0, pass <= 0.
//   - Latency: seg_out shows the high nibble on the cycle after the strobe.
//   - A new strobe mid-display restarts the sequence with the new value.
//   - A strobe wins over any dwell expiry in the same cycle.
//   Dwell counter
//   - Counts 0..DWELL_CYCLES-1 in SHOW_HI and in SHOW_LO.
//   - On terminal count it clears to 0 and the state advances. Each nibble is
//     therefore shown for exactly DWELL_CYCLES enabled cycles.
//   Transitions
//   - SHOW_HI terminal -> SHOW_LO.
//   - SHOW_LO terminal, REPEATS != 0 and pass == REPEATS-1 -> IDLE.
//   - SHOW_LO terminal, otherwise -> pass <= pass+1 and SHOW_HI.
//   - With REPEATS = 0 the pass counter never stops the sequence and wraps
//     silently.
//   Hex map (seg[6:0])
//     0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
//     8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
//   Edge cases
//   - DWELL_CYCLES = 1: the display alternates HI/LO every cycle.
//   - result_in is sampled only on the strobe cycle; later changes have no effect.
// TESTING (DWELL_CYCLES=4, REPEATS=2 unless noted)
//   1. Reset: assert rst_n=0 mid-SHOW_LO -> same-cycle seg_out=00, busy=0;
//      after release, stays IDLE with no strobe.
//   2. Strobe result_in=8'h3C -> next cycle seg_out=CF (dp + '3') for 4 cycles,
//      then 39 ('C') for 4 cycles, repeated twice (16 cycles busy), then
//      seg_out=00, busy=0.
//   3. Strobe 8'hA5, then strobe 8'h7E at cycle 6 -> next cycle seg_out=87
//      (dp + '7'); the full 16-cycle sequence restarts for 7E.
//   4. ena=0 for 10 cycles during SHOW_HI of 8'h12 -> seg_out stays 86; a strobe
//      while ena=0 is ignored; the remaining dwell completes after ena returns to 1.
//   5. REPEATS=0, strobe 8'hF0 -> F1/3F alternate every 4 cycles for 200+ cycles;
//      busy never drops.
//   6. Sweep all 16 nibble values through result_in[3:0] -> each SHOW_LO value
//      matches the hex map exactly.

Source files
------------

// File: rtl/result_hex_display.sv
// Shows a captured 8-bit product on one 7-segment digit as alternating hex nibbles,
// high nibble with the decimal point lit, for a fixed number of passes before blanking.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | display blank, waiting for a result strobe
// SHOW_HI | high nibble shown with decimal point lit
// SHOW_LO | low nibble shown, decimal point off
module result_hex_display #(
    parameter logic [23:0] DWELL_CYCLES = 24'd10_000_000,
    parameter logic [3:0]  REPEATS      = 4'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] result_in,
    input  logic       result_valid,
    output logic [7:0] seg_out,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW_HI = 2'd1,
        SHOW_LO = 2'd2
    } state_t;

    localparam logic [23:0] DWELL_LAST = DWELL_CYCLES - 24'd1;
    localparam logic [3:0]  PASS_LAST  = REPEATS - 4'd1;

    state_t      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [23:0] dwell_q, dwell_d;
    logic [3:0]  pass_q, pass_d;
    logic [7:0]  seg_q, seg_d;
    logic        busy_q, busy_d;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        dwell_d = dwell_q;
        pass_d  = pass_q;

        if (ena) begin
            // A strobe overrides any terminal count landing in the same cycle.
            if (result_valid) begin
                state_d = SHOW_HI;
                hold_d  = result_in;
                dwell_d = 24'd0;
                pass_d  = 4'd0;
            end else begin
                case (state_q)
                    SHOW_HI: begin
                        if (dwell_q == DWELL_LAST) begin
                            dwell_d = 24'd0;
                            state_d = SHOW_LO;
                        end else begin
                            dwell_d = dwell_q + 24'd1;
                        end
                    end
                    SHOW_LO: begin
                        if (dwell_q == DWELL_LAST) begin
                            dwell_d = 24'd0;
                            if ((REPEATS != 4'd0) && (pass_q == PASS_LAST)) begin
                                state_d = IDLE;
                            end else begin
                                pass_d  = pass_q + 4'd1;
                                state_d = SHOW_HI;
                            end
                        end else begin
                            dwell_d = dwell_q + 24'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Outputs are decoded from the next state so they register alongside it.
        case (state_d)
            SHOW_HI: seg_d = {1'b1, hex7(hold_d[7:4])};
            SHOW_LO: seg_d = {1'b0, hex7(hold_d[3:0])};
            default: seg_d = 8'h00;
        endcase
        busy_d = (state_d == SHOW_HI) || (state_d == SHOW_LO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= 8'h00;
            dwell_q <= 24'd0;
            pass_q  <= 4'd0;
            seg_q   <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            dwell_q <= dwell_d;
            pass_q  <= pass_d;
            seg_q   <= seg_d;
            busy_q  <= busy_d;
        end
    end

    assign seg_out = seg_q;
    assign busy    = busy_q;

endmodule
